// File: rtl/signed_minmax_tracker_if.sv
// rtl/signed_minmax_tracker_if.sv - sample-in / window-result-out handshake bundle for signed_minmax_tracker
//
// Purpose: groups the input sample stream and the window result stream into one bundle.
// Parameters:
//   WIDTH : sample width in bits (signed two's complement)
//   CNT_W : index width; exists only when MINMAX_INDEX_EN is defined
// Signals:
//   in_valid / in_data / in_ready        : sample handshake (upstream -> tracker)
//   out_valid / out_ready                : result handshake (tracker -> consumer)
//   out_min / out_max                    : signed window minimum / maximum
//   out_range                            : unsigned max - min, WIDTH+1 bits
//   out_min_idx / out_max_idx            : first-occurrence positions (MINMAX_INDEX_EN only)
// Modports:
//   master : environment side (drives samples, consumes results)
//   slave  : tracker side
interface signed_minmax_tracker_if #(
    parameter int WIDTH = 4
`ifdef MINMAX_INDEX_EN
    ,
    parameter int CNT_W = 8
`endif
);
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_min;
    logic [WIDTH-1:0]   out_max;
    logic [WIDTH:0]     out_range;
`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0]   out_min_idx;
    logic [CNT_W-1:0]   out_max_idx;
`endif

    modport master (
        output in_valid, in_data, out_ready,
`ifdef MINMAX_INDEX_EN
        input  out_min_idx, out_max_idx,
`endif
        input  in_ready, out_valid, out_min, out_max, out_range
    );

    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef MINMAX_INDEX_EN
        output out_min_idx, out_max_idx,
`endif
        output in_ready, out_valid, out_min, out_max, out_range
    );
endinterface

// File: rtl/signed_minmax_tracker.sv
// rtl/signed_minmax_tracker.sv - windowed signed min/max/range tracker with valid/ready streams
//
// Purpose: accumulates WINDOW signed samples, then presents min, max and range of
// the window until the consumer accepts it.
// Optional feature macro: MINMAX_INDEX_EN adds out_min_idx / out_max_idx (first
// occurrence positions within the window).
// Parameters:
//   WIDTH  : sample width (signed)
//   WINDOW : samples per window, 2..255
//   CNT_W  : sample counter width, 2**CNT_W > WINDOW
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   clear  : synchronous abort of the current window / pending result
//   bus    : signed_minmax_tracker_if.slave (sample in, result out)
module signed_minmax_tracker #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    signed_minmax_tracker_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]              state;
    logic [CNT_W-1:0]        count;
    logic signed [WIDTH-1:0] run_min;
    logic signed [WIDTH-1:0] run_max;
    logic [WIDTH-1:0]        res_min;
    logic [WIDTH-1:0]        res_max;
    logic [WIDTH:0]          res_range;
    logic                    res_valid;
`ifdef MINMAX_INDEX_EN
    logic [CNT_W-1:0]        run_min_idx;
    logic [CNT_W-1:0]        run_max_idx;
    logic [CNT_W-1:0]        res_min_idx;
    logic [CNT_W-1:0]        res_max_idx;
    logic [CNT_W-1:0]        next_min_idx;
    logic [CNT_W-1:0]        next_max_idx;
`endif

    logic                    ready;
    logic                    accept;
    logic                    last;
    logic signed [WIDTH-1:0] sample;
    logic                    sample_lt;
    logic                    sample_gt;
    logic signed [WIDTH-1:0] next_min;
    logic signed [WIDTH-1:0] next_max;
    logic [WIDTH:0]          next_range;

    assign ready  = (state != HOLD);
    assign accept = bus.in_valid & ready;
    assign sample = $signed(bus.in_data);
    // count holds the number of samples already in the window, so this sample
    // completes it when count is one short of WINDOW.
    assign last   = (count == CNT_W'(WINDOW - 1));

    always_comb begin
        sample_lt  = (sample < run_min);
        sample_gt  = (sample > run_max);
        // Strict compares: equal samples never displace the held value.
        next_min   = sample_lt ? sample : run_min;
        next_max   = sample_gt ? sample : run_max;
        // One extra bit on both operands keeps max - min from wrapping (e.g. 7 - -8 = 15).
        next_range = {next_max[WIDTH-1], next_max} - {next_min[WIDTH-1], next_min};
`ifdef MINMAX_INDEX_EN
        next_min_idx = sample_lt ? count : run_min_idx;
        next_max_idx = sample_gt ? count : run_max_idx;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            run_min   <= '0;
            run_max   <= '0;
            res_min   <= '0;
            res_max   <= '0;
            res_range <= '0;
            res_valid <= 1'b0;
`ifdef MINMAX_INDEX_EN
            run_min_idx <= '0;
            run_max_idx <= '0;
            res_min_idx <= '0;
            res_max_idx <= '0;
`endif
        end else if (clear) begin
            // Result registers deliberately keep their last values.
            state     <= IDLE;
            count     <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        run_min <= sample;
                        run_max <= sample;
                        count   <= CNT_W'(1);
`ifdef MINMAX_INDEX_EN
                        run_min_idx <= '0;
                        run_max_idx <= '0;
`endif
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        run_min <= next_min;
                        run_max <= next_max;
                        count   <= count + CNT_W'(1);
`ifdef MINMAX_INDEX_EN
                        run_min_idx <= next_min_idx;
                        run_max_idx <= next_max_idx;
`endif
                        if (last) begin
                            res_min   <= next_min;
                            res_max   <= next_max;
                            res_range <= next_range;
                            res_valid <= 1'b1;
`ifdef MINMAX_INDEX_EN
                            res_min_idx <= next_min_idx;
                            res_max_idx <= next_max_idx;
`endif
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        res_valid <= 1'b0;
                        count     <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = res_valid;
    assign bus.out_min   = res_min;
    assign bus.out_max   = res_max;
    assign bus.out_range = res_range;
`ifdef MINMAX_INDEX_EN
    assign bus.out_min_idx = res_min_idx;
    assign bus.out_max_idx = res_max_idx;
`endif
endmodule

// File: tb/tb_signed_minmax_tracker.sv
// tb/tb_signed_minmax_tracker.sv - scoreboard bench for signed_minmax_tracker (WINDOW=4)
module tb_signed_minmax_tracker;
    localparam int W   = 4;
    localparam int WIN = 4;
    localparam int CW  = 8;

    typedef struct {
        logic [W-1:0]  mn;
        logic [W-1:0]  mx;
        logic [W:0]    rng;
        logic [CW-1:0] mn_idx;
        logic [CW-1:0] mx_idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   win[$];

    always #5 clk = ~clk;

    signed_minmax_tracker_if #(.WIDTH(W)) bus();

    signed_minmax_tracker #(.WIDTH(W), .WINDOW(WIN), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    // Reference: recompute min/max (first occurrence, strict) over the stored window.
    task automatic model_push(input int v);
        exp_t e;
        int mn, mx, mi, xi;
        win.push_back(v);
        if (win.size() == WIN) begin
            mn = win[0]; mx = win[0]; mi = 0; xi = 0;
            for (int i = 1; i < WIN; i++) begin
                if (win[i] < mn) begin mn = win[i]; mi = i; end
                if (win[i] > mx) begin mx = win[i]; xi = i; end
            end
            e.mn = W'(mn); e.mx = W'(mx); e.rng = (W+1)'(mx - mn);
            e.mn_idx = CW'(mi); e.mx_idx = CW'(xi);
            sb.push_back(e);
            win.delete();
        end
    endtask

    // Starts and ends at a negedge.
    task automatic send(input int v);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = W'(v);
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        model_push(v);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_result(input string name);
        exp_t e;
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s out_valid_timeout got %b required 1", name, bus.out_valid);
        end
        if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL %s scoreboard_empty got 0 entries required 1", name);
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (bus.out_min !== e.mn) begin
            miscompares++;
            $display("FAIL %s out_min got %h required %h", name, bus.out_min, e.mn);
        end
        vectors++;
        if (bus.out_max !== e.mx) begin
            miscompares++;
            $display("FAIL %s out_max got %h required %h", name, bus.out_max, e.mx);
        end
        vectors++;
        if (bus.out_range !== e.rng) begin
            miscompares++;
            $display("FAIL %s out_range got %0d required %0d", name, bus.out_range, e.rng);
        end
`ifdef MINMAX_INDEX_EN
        vectors++;
        if (bus.out_min_idx !== e.mn_idx || bus.out_max_idx !== e.mx_idx) begin
            miscompares++;
            $display("FAIL %s idx got %0d/%0d required %0d/%0d", name,
                     bus.out_min_idx, bus.out_max_idx, e.mn_idx, e.mx_idx);
        end
`endif
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s out_valid_drop got %b required 0", name, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_range} !== {1'b0, 13'd0}) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b %h %h %h required 0", bus.out_valid,
                     bus.out_min, bus.out_max, bus.out_range);
        end
`ifdef MINMAX_INDEX_EN
        vectors++;
        if ({bus.out_min_idx, bus.out_max_idx} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_idx got %0d/%0d required 0/0", bus.out_min_idx, bus.out_max_idx);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_extremes();
        send(3); send(-2); send(7);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL extremes_early_valid got %b required 0", bus.out_valid);
        end
        send(-8);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_min !== 4'b1000 || bus.out_max !== 4'b0111 ||
            bus.out_range !== 5'd15) begin
            miscompares++;
            $display("FAIL extremes_latency got v=%b min=%h max=%h rng=%0d required 1 8 7 15",
                     bus.out_valid, bus.out_min, bus.out_max, bus.out_range);
        end
        check_result("extremes");
    endtask

    task automatic test_all_equal();
        for (int i = 0; i < WIN; i++) send(-1);
        check_result("all_equal");
    endtask

    task automatic test_hold_stall();
        exp_t snap;
        send(1); send(2); send(3); send(4);
        if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL hold_scoreboard_empty got 0 required 1");
            return;
        end
        snap = sb[0];
        bus.in_valid = 1'b1; bus.in_data = 4'd5; bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({bus.in_ready, bus.out_valid, bus.out_min, bus.out_max, bus.out_range} !==
                {1'b0, 1'b1, snap.mn, snap.mx, snap.rng}) begin
                miscompares++;
                $display("FAIL hold_stall cycle %0d got rdy=%b v=%b %h %h %0d required 0 1 %h %h %0d",
                         i, bus.in_ready, bus.out_valid, bus.out_min, bus.out_max, bus.out_range,
                         snap.mn, snap.mx, snap.rng);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        void'(sb.pop_front());
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release got v=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        model_push(5);
        @(negedge clk);
        bus.in_valid = 1'b0;
        send(6); send(-1); send(0);
        check_result("after_hold");
    endtask

    task automatic test_clear();
        exp_t snap;
        send(5); send(2);
        bus.in_valid = 1'b1; bus.in_data = 4'd0; clear = 1'b1;
        @(posedge clk);
        win.delete();
        @(negedge clk);
        clear = 1'b0; bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_valid got %b required 0", bus.out_valid);
        end
        send(1); send(2); send(3); send(4);
        vectors++;
        if (bus.out_min !== 4'd1 || bus.out_max !== 4'd4 || bus.out_range !== 5'd3) begin
            miscompares++;
            $display("FAIL clear_window got %h %h %0d required 1 4 3",
                     bus.out_min, bus.out_max, bus.out_range);
        end
        check_result("after_clear");
        send(0); send(1); send(0); send(1);
        snap = sb.pop_front();
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_min !== snap.mn || bus.out_max !== snap.mx) begin
            miscompares++;
            $display("FAIL clear_in_hold got v=%b %h %h required 0 %h %h",
                     bus.out_valid, bus.out_min, bus.out_max, snap.mn, snap.mx);
        end
    endtask

    task automatic test_gaps();
        send(-3); repeat (2) @(negedge clk);
        send(0);  repeat (2) @(negedge clk);
        send(6);  repeat (2) @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_early_valid got %b required 0", bus.out_valid);
        end
        send(-5);
        vectors++;
        if (bus.out_min !== 4'hB || bus.out_max !== 4'd6 || bus.out_range !== 5'd11) begin
            miscompares++;
            $display("FAIL gaps_window got %h %h %0d required b 6 11",
                     bus.out_min, bus.out_max, bus.out_range);
        end
        check_result("gaps");
    endtask

    task automatic test_async_reset();
        send(1); send(2);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_range} !== {1'b0, 13'd0}) begin
            miscompares++;
            $display("FAIL async_rst_accum got v=%b %h %h %0d required 0", bus.out_valid,
                     bus.out_min, bus.out_max, bus.out_range);
        end
        win.delete();
        @(negedge clk);
        rst = 1'b0;
        send(3); send(-4); send(2); send(1);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_range} !== {1'b0, 13'd0}) begin
            miscompares++;
            $display("FAIL async_rst_hold got v=%b %h %h %0d required 0", bus.out_valid,
                     bus.out_min, bus.out_max, bus.out_range);
        end
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        send(7); send(7); send(-8); send(0);
        check_result("after_reset");
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        test_reset();
        test_extremes();
        test_all_equal();
        test_hold_stall();
        test_clear();
        test_gaps();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
